wb_commit_unit: RTL and testbench

WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

---
 rtl/wb_pkg.sv | 8 +
 rtl/reg_access_executor.sv | 10 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/wb_commit_unit.sv | 77 +++++++
 tb/tb_wb_commit_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back entry type and default buffer depth.
package wb_pkg;
  localparam int WB_DEPTH_DEFAULT = 2;
  typedef struct packed {
    logic [3:0]  loc;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_access_executor.sv
// reg_access_executor: register-file write/read bundle between execute-side units and the register file.
interface reg_access_executor;
  logic [3:0]  write_loc;
  logic [31:0] write_data;
  logic        do_write;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  modport front (output write_loc, write_data, do_write, input read_data_1, read_data_2);
  modport back (input write_loc, write_data, do_write, output read_data_1, read_data_2);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order write-back buffer; pops its head on every edge while non-empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  push,
  input  wb_entry_t             din,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  output wb_entry_t [DEPTH-1:0] ents,
  output logic      [DEPTH-1:0] vlds
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic pop, do_push;
  assign empty   = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign pop     = !empty;
  assign do_push = push && !full;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[tail_q] = din;
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = do_push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(do_push) - CW'(pop);
    head    = empty ? '0 : mem_q[head_q];
    // entries listed oldest first so callers can pick the youngest match by scanning upward
    for (int i = 0; i < DEPTH; i++) begin
      ents[i] = mem_q[head_q + AW'(i)];
      vlds[i] = CW'(i) < count_q;
    end
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: buffers execute results and commits them to the register file in order.
// Optional WB_COMMIT_FORWARD_EN replaces the hazard flag with per-source forwarding outputs.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [3:0]        res_loc,
  input  logic [31:0]       res_data,
  reg_access_executor.front rf,
  input  logic [3:0]        chk_loc_1,
  input  logic [3:0]        chk_loc_2,
  output logic              hazard,
  output logic              idle
`ifdef WB_COMMIT_FORWARD_EN
  ,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [31:0]       fwd_data_1,
  output logic [31:0]       fwd_data_2
`endif
);
  wb_entry_t head;
  wb_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0] vlds;
  logic empty, full, push;
  logic unused_rd;
  assign res_ready     = !full;
  assign push          = res_valid && res_ready && res_loc != 4'd0;
  assign idle          = empty;
  assign rf.write_loc  = head.loc;
  assign rf.write_data = head.data;
  assign rf.do_write   = !empty;
  assign unused_rd     = ^{rf.read_data_1, rf.read_data_2};
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .nreset(nreset),
    .push  (push),
    .din   ('{loc: res_loc, data: res_data}),
    .head  (head),
    .empty (empty),
    .full  (full),
    .ents  (ents),
    .vlds  (vlds)
  );
`ifdef WB_COMMIT_FORWARD_EN
  assign hazard = 1'b0;
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vlds[i] && chk_loc_1 != 4'd0 && ents[i].loc == chk_loc_1) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = ents[i].data;
      end
      if (vlds[i] && chk_loc_2 != 4'd0 && ents[i].loc == chk_loc_2) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = ents[i].data;
      end
    end
  end
`else
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vlds[i] && ((chk_loc_1 != 4'd0 && ents[i].loc == chk_loc_1) ||
                      (chk_loc_2 != 4'd0 && ents[i].loc == chk_loc_2)))
        hazard = 1'b1;
  end
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: scoreboard bench for wb_commit_unit; honours WB_COMMIT_FORWARD_EN.
module tb_wb_commit_unit;
  import wb_pkg::*;
  localparam int DEPTH = 2;
  logic clock = 1'b0;
  logic nreset, res_valid, res_ready, hazard, idle;
  logic [3:0] res_loc, chk_loc_1, chk_loc_2;
  logic [31:0] res_data;
  int n_checks = 0;
  int n_errors = 0;
  wb_entry_t q[$];
  reg_access_executor rf_if ();
  assign rf_if.read_data_1 = '0;
  assign rf_if.read_data_2 = '0;
`ifdef WB_COMMIT_FORWARD_EN
  logic fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif
  always #5 clock = ~clock;
  wb_commit_unit #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .nreset   (nreset),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_loc  (res_loc),
    .res_data (res_data),
    .rf       (rf_if),
    .chk_loc_1(chk_loc_1),
    .chk_loc_2(chk_loc_2),
    .hazard   (hazard),
    .idle     (idle)
`ifdef WB_COMMIT_FORWARD_EN
    ,
    .fwd_hit_1 (fwd_hit_1),
    .fwd_hit_2 (fwd_hit_2),
    .fwd_data_1(fwd_data_1),
    .fwd_data_2(fwd_data_2)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: the queue is the buffer contents, oldest first
  always @(posedge clock or negedge nreset) begin
    if (!nreset) q.delete();
    else begin
      automatic bit acc = res_valid && (q.size() < DEPTH);
      if (q.size() != 0) void'(q.pop_front());
      if (acc && res_loc != 4'd0) q.push_back('{loc: res_loc, data: res_data});
    end
  end
  always @(negedge clock) begin
    automatic logic hz = 1'b0;
    automatic logic h1 = 1'b0, h2 = 1'b0;
    automatic logic [31:0] d1 = '0, d2 = '0;
    foreach (q[i]) begin
      if (chk_loc_1 != 4'd0 && q[i].loc == chk_loc_1) begin hz = 1'b1; h1 = 1'b1; d1 = q[i].data; end
      if (chk_loc_2 != 4'd0 && q[i].loc == chk_loc_2) begin hz = 1'b1; h2 = 1'b1; d2 = q[i].data; end
    end
    check("res_ready", 32'(res_ready), 32'(q.size() < DEPTH));
    check("idle", 32'(idle), 32'(q.size() == 0));
    check("do_write", 32'(rf_if.do_write), 32'(q.size() != 0));
`ifdef WB_COMMIT_FORWARD_EN
    check("hazard", 32'(hazard), 32'd0);
    check("fwd_hit_1", 32'(fwd_hit_1), 32'(h1));
    check("fwd_hit_2", 32'(fwd_hit_2), 32'(h2));
    if (h1) check("fwd_data_1", fwd_data_1, d1);
    if (h2) check("fwd_data_2", fwd_data_2, d2);
`else
    check("hazard", 32'(hazard), 32'(hz));
`endif
    if (q.size() != 0) begin
      check("write_loc", 32'(rf_if.write_loc), 32'(q[0].loc));
      check("write_data", rf_if.write_data, q[0].data);
    end
  end
  task automatic step(input logic v, input logic [3:0] loc, input logic [31:0] data);
    res_valid = v;
    res_loc   = loc;
    res_data  = data;
    @(posedge clock);
    #1;
  endtask
  task automatic check_cleared(input string tag);
    check({tag, "_do_write"}, 32'(rf_if.do_write), 32'd0);
    check({tag, "_hazard"}, 32'(hazard), 32'd0);
    check({tag, "_ready"}, 32'(res_ready), 32'd1);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_wloc"}, 32'(rf_if.write_loc), 32'd0);
    check({tag, "_wdata"}, rf_if.write_data, 32'd0);
  endtask
  initial begin
    nreset = 1'b0;
    res_valid = 1'b0;
    res_loc = '0;
    res_data = '0;
    chk_loc_1 = '0;
    chk_loc_2 = '0;
    #1;
    check_cleared("rst");
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
    step(1'b1, 4'd5, 32'hDEADBEEF);
    check("sw_do_write", 32'(rf_if.do_write), 32'd1);
    check("sw_loc", 32'(rf_if.write_loc), 32'd5);
    check("sw_data", rf_if.write_data, 32'hDEADBEEF);
    check("sw_busy", 32'(idle), 32'd0);
    step(1'b0, 4'd0, 32'd0);
    check("sw_idle", 32'(idle), 32'd1);
    step(1'b1, 4'd0, 32'h1234);
    check("x0_do_write", 32'(rf_if.do_write), 32'd0);
    check("x0_idle", 32'(idle), 32'd1);
    check("x0_hazard", 32'(hazard), 32'd0);
    step(1'b1, 4'd1, 32'd10);
    step(1'b1, 4'd2, 32'd20);
    step(1'b1, 4'd3, 32'd30);
    check("fill_ready", 32'(res_ready), 32'd1);
    step(1'b0, 4'd0, 32'd0);
    step(1'b0, 4'd0, 32'd0);
    chk_loc_1 = 4'd7;
    step(1'b1, 4'd7, 32'h77);
`ifndef WB_COMMIT_FORWARD_EN
    check("hz_set", 32'(hazard), 32'd1);
`endif
    step(1'b0, 4'd0, 32'd0);
    check("hz_clear", 32'(hazard), 32'd0);
    chk_loc_1 = 4'd0;
    step(1'b1, 4'd0, 32'd5);
    check("hz_x0", 32'(hazard), 32'd0);
`ifdef WB_COMMIT_FORWARD_EN
    chk_loc_2 = 4'd4;
    step(1'b1, 4'd4, 32'hA);
    step(1'b1, 4'd4, 32'hB);
    check("fwd_hit", 32'(fwd_hit_2), 32'd1);
    check("fwd_data", fwd_data_2, 32'hB);
    check("fwd_hazard", 32'(hazard), 32'd0);
    chk_loc_2 = 4'd0;
`endif
    step(1'b1, 4'd9, 32'h99);
    step(1'b1, 4'd10, 32'hAA);
    res_valid = 1'b0;
    #1 nreset = 1'b0;
    #1 check_cleared("mid_rst");
    #1 nreset = 1'b1;
    repeat (3) begin
      step(1'b0, 4'd0, 32'd0);
      check("post_rst_do_write", 32'(rf_if.do_write), 32'd0);
    end
    repeat (300) begin
      chk_loc_1 = 4'($urandom_range(0, 15));
      chk_loc_2 = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    repeat (4) step(1'b0, 4'd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
